// File: rtl/ahb_tri_arbiter.sv
// Round-robin AHB arbiter: grants one tri-state master wrapper at a time, holding the
// grant across fixed-length bursts and locked sequences, and parking on a default master.
module ahb_tri_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTERD,
  output logic                   HMASTLOCK
);

  localparam logic [2:0] ST_PARK     = 3'd0;
  localparam logic [2:0] ST_OWNED    = 3'd1;
  localparam logic [2:0] ST_BURST    = 3'd2;
  localparam logic [2:0] ST_LOCK     = 3'd3;
  localparam logic [2:0] ST_LOCKTAIL = 3'd4;

  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'd0;

  localparam logic [NUM_MASTERS-1:0] GRANT_ONE     = NUM_MASTERS'(1);
  localparam logic [NUM_MASTERS-1:0] GRANT_DEFAULT = GRANT_ONE << DEFAULT_MASTER;
  localparam logic [MW-1:0]          IDX_DEFAULT   = MW'(DEFAULT_MASTER);

  logic [2:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    next_cnt;
  logic [MW-1:0] rr_ptr;
  logic [MW-1:0] grant_idx;
  logic [MW-1:0] winner_idx;
  logic [MW-1:0] scan_idx;
  logic [MW-1:0] bit_idx;
  logic          winner_found;
  logic          lock_hold;
  logic          arb_ok;
  logic          err_first;

  always_comb begin
    grant_idx = '0;
    bit_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bit_idx = MW'(i);
      if (HGRANT[bit_idx]) grant_idx = bit_idx;
    end
  end

  // Beat counter after this edge: fixed bursts load beats-1, SEQ counts down.
  always_comb begin
    next_cnt = cnt;
    case (HTRANS)
      TR_NONSEQ: begin
        case (HBURST)
          3'd2, 3'd3: next_cnt = 4'd3;
          3'd4, 3'd5: next_cnt = 4'd7;
          3'd6, 3'd7: next_cnt = 4'd15;
          default:    next_cnt = 4'd0;
        endcase
      end
      TR_SEQ:  next_cnt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      default: next_cnt = cnt;
    endcase
  end

  // Being in LOCK means the previous edge saw HLOCK, so one more transfer is held.
  assign lock_hold = HLOCK[grant_idx] || (state == ST_LOCK);
  assign arb_ok    = !lock_hold && (next_cnt <= 4'd1);
  assign err_first = !HREADY && (HRESP != RESP_OKAY);

  always_comb begin
    winner_found = 1'b0;
    winner_idx   = rr_ptr;
    scan_idx     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!winner_found && HBUSREQ[scan_idx]) begin
        winner_found = 1'b1;
        winner_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HGRANT    <= GRANT_DEFAULT;
      HMASTER   <= IDX_DEFAULT;
      HMASTERD  <= IDX_DEFAULT;
      HMASTLOCK <= 1'b0;
      cnt       <= 4'd0;
      rr_ptr    <= IDX_DEFAULT;
      state     <= ST_PARK;
    end else if (HREADY) begin
      HMASTER   <= grant_idx;
      HMASTERD  <= HMASTER;
      HMASTLOCK <= HLOCK[grant_idx];
      cnt       <= next_cnt;
      if (lock_hold) begin
        state <= HLOCK[grant_idx] ? ST_LOCK : ST_LOCKTAIL;
      end else if (!arb_ok) begin
        state <= ST_BURST;
      end else if (winner_found) begin
        HGRANT <= GRANT_ONE << winner_idx;
        rr_ptr <= winner_idx;
        state  <= ST_OWNED;
      end else begin
        HGRANT <= GRANT_DEFAULT;
        state  <= ST_PARK;
      end
    end else if (err_first) begin
      cnt <= 4'd0;
      if (state == ST_BURST) state <= ST_OWNED;
    end
  end

endmodule
